fft_frame_sequencer: RTL

//  Schedules the three frame stages: AXIS->BRAM load, in-place FFT, BRAM->AXIS drain.

---
 rtl/fft_frame_sequencer_pkg.sv | 34 +++
 rtl/fft_stage_ctrl.sv | 82 ++++++++
 rtl/fft_frame_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_pkg.sv
// Shared encodings for the FFT frame sequencer: ping-pong bank states,
// one-hot stage FSM states and the bank rollback applied on a start timeout.
package fft_frame_sequencer_pkg;

    localparam int unsigned NUM_BANKS         = 2;
    localparam int unsigned TIMEOUT_CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        BANK_FREE      = 3'd0,
        BANK_LOADING   = 3'd1,
        BANK_LOADED    = 3'd2,
        BANK_COMPUTING = 3'd3,
        BANK_COMPUTED  = 3'd4,
        BANK_DRAINING  = 3'd5
    } bank_state_e;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_GO   = 4'b0010,
        ST_WAIT = 4'b0100,
        ST_RUN  = 4'b1000
    } stage_state_e;

    // A stage that never acknowledged its go leaves the bank as it found it.
    function automatic bank_state_e timeout_revert(input bank_state_e s);
        case (s)
            BANK_LOADING:   return BANK_FREE;
            BANK_COMPUTING: return BANK_LOADED;
            BANK_DRAINING:  return BANK_COMPUTED;
            default:        return s;
        endcase
    endfunction

endpackage

// File: rtl/fft_stage_ctrl.sv
// Generic go/busy handshake for one frame stage, with a start timeout and a
// bank pointer that flips each time the stage completes a frame.
module fft_stage_ctrl
    import fft_frame_sequencer_pkg::*;
#(
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic hold,
    output logic go,
    output logic done,
    output logic timeout,
    output logic bank,
    output logic active
);

    // Counter holds the number of cycles elapsed since go, so the timeout
    // pulse fires one cycle before the limit and the sticky error lands on it.
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] CNT_LIMIT = TIMEOUT_CNT_WIDTH'(START_TIMEOUT - 1);

    stage_state_e                 state_q, state_d;
    logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                         ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        go      = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !hold) begin
                    state_d = ST_GO;
                end
            end
            ST_GO: begin
                go      = 1'b1;
                cnt_d   = TIMEOUT_CNT_WIDTH'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (busy) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_CNT_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    done    = 1'b1;
                    ptr_d   = ~ptr_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bank   = ptr_q;
    assign active = (state_q != ST_IDLE);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Schedules load, FFT and drain stages over two ping-pong BRAM banks so that
// loading of the next frame overlaps processing of the current one.
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_CNT_WIDTH = 16,
    parameter int unsigned START_TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seq_enable,
    output logic                       load_go,
    input  logic                       load_busy,
    output logic                       load_bank,
    output logic                       fft_go,
    input  logic                       fft_busy,
    output logic                       fft_bank,
    output logic                       axis_bram_master_go,
    input  logic                       axis_bram_master_busy,
    output logic                       drain_bank,
    output logic [FRAME_CNT_WIDTH-1:0] frames_done,
    output logic                       seq_idle,
    output logic                       seq_error
);

    bank_state_e                bank_q [NUM_BANKS];
    bank_state_e                bank_d [NUM_BANKS];
    logic [FRAME_CNT_WIDTH-1:0] frames_q, frames_d;
    logic                       error_q, error_d;

    logic load_fire, fft_fire, drain_fire;
    logic load_done, fft_done, drain_done;
    logic load_to, fft_to, drain_to;
    logic load_active, fft_active, drain_active;
    logic hold;

    fft_stage_ctrl #(.START_TIMEOUT(START_TIMEOUT)) u_load (
        .clk     (clk),
        .reset   (reset),
        .start   (load_fire),
        .busy    (load_busy),
        .hold    (hold),
        .go      (load_go),
        .done    (load_done),
        .timeout (load_to),
        .bank    (load_bank),
        .active  (load_active)
    );

    fft_stage_ctrl #(.START_TIMEOUT(START_TIMEOUT)) u_fft (
        .clk     (clk),
        .reset   (reset),
        .start   (fft_fire),
        .busy    (fft_busy),
        .hold    (hold),
        .go      (fft_go),
        .done    (fft_done),
        .timeout (fft_to),
        .bank    (fft_bank),
        .active  (fft_active)
    );

    fft_stage_ctrl #(.START_TIMEOUT(START_TIMEOUT)) u_drain (
        .clk     (clk),
        .reset   (reset),
        .start   (drain_fire),
        .busy    (axis_bram_master_busy),
        .hold    (hold),
        .go      (axis_bram_master_go),
        .done    (drain_done),
        .timeout (drain_to),
        .bank    (drain_bank),
        .active  (drain_active)
    );

    // A timeout in the current cycle already blocks starts, so no go can
    // slip out in the cycle the sticky error becomes visible.
    always_comb begin
        hold       = error_q | load_to | fft_to | drain_to;
        load_fire  = seq_enable & ~load_active & (bank_q[load_bank] == BANK_FREE) & ~hold;
        fft_fire   = ~fft_active & (bank_q[fft_bank] == BANK_LOADED) & ~hold;
        drain_fire = ~drain_active & (bank_q[drain_bank] == BANK_COMPUTED) & ~hold;
    end

    always_comb begin
        bank_d = bank_q;
        if (load_fire)  bank_d[load_bank]  = BANK_LOADING;
        if (load_done)  bank_d[load_bank]  = BANK_LOADED;
        if (load_to)    bank_d[load_bank]  = timeout_revert(bank_q[load_bank]);
        if (fft_fire)   bank_d[fft_bank]   = BANK_COMPUTING;
        if (fft_done)   bank_d[fft_bank]   = BANK_COMPUTED;
        if (fft_to)     bank_d[fft_bank]   = timeout_revert(bank_q[fft_bank]);
        if (drain_fire) bank_d[drain_bank] = BANK_DRAINING;
        if (drain_done) bank_d[drain_bank] = BANK_FREE;
        if (drain_to)   bank_d[drain_bank] = timeout_revert(bank_q[drain_bank]);
        frames_d = frames_q + FRAME_CNT_WIDTH'(drain_done);
        error_d  = error_q | load_to | fft_to | drain_to;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= BANK_FREE;
            end
            frames_q <= '0;
            error_q  <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            frames_q <= frames_d;
            error_q  <= error_d;
        end
    end

    assign frames_done = frames_q;
    assign seq_error   = error_q;
    assign seq_idle    = (bank_q[0] == BANK_FREE) & (bank_q[1] == BANK_FREE) &
                         ~load_active & ~fft_active & ~drain_active;

endmodule
